// File: rtl/br_exec_unit.sv
// Branch/jump execution unit: resolves branch/JAL/JALR outcomes in E and holds
// the link result in W until the CDB arbiter grants it; mispredicts raise a redirect.
module br_exec_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PREG_BITS = 6,
    parameter int unsigned ROB_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 br_is_ready,
    input  logic [2:0]           in_funct3,
    input  logic                 in_is_jal,
    input  logic                 in_is_jalr,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_rs1_v,
    input  logic [XLEN-1:0]      in_rs2_v,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [PREG_BITS-1:0] in_pd,
    input  logic [ROB_BITS-1:0]  in_rob_idx,
    input  logic                 in_pred_taken,
    input  logic [XLEN-1:0]      in_pred_target,
    output logic                 cdb_req,
    input  logic                 cdb_grant,
    output logic                 cdb_valid,
    output logic [PREG_BITS-1:0] cdb_pd,
    output logic [ROB_BITS-1:0]  cdb_rob_idx,
    output logic [XLEN-1:0]      cdb_data,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic [ROB_BITS-1:0]  redirect_rob_idx,
    output logic [31:0]          mispred_cnt
);

    localparam logic [2:0] F3_EQ  = 3'b000;
    localparam logic [2:0] F3_NE  = 3'b001;
    localparam logic [2:0] F3_LT  = 3'b100;
    localparam logic [2:0] F3_GE  = 3'b101;
    localparam logic [2:0] F3_LTU = 3'b110;
    localparam logic [2:0] F3_GEU = 3'b111;

    // E stage: operands captured from the reservation station
    logic                 e_valid;
    logic [2:0]           e_funct3;
    logic                 e_is_jal;
    logic                 e_is_jalr;
    logic [XLEN-1:0]      e_pc;
    logic [XLEN-1:0]      e_rs1_v;
    logic [XLEN-1:0]      e_rs2_v;
    logic [XLEN-1:0]      e_imm;
    logic [PREG_BITS-1:0] e_pd;
    logic [ROB_BITS-1:0]  e_rob_idx;
    logic                 e_pred_taken;
    logic [XLEN-1:0]      e_pred_target;

    // W stage: resolved result waiting for a CDB grant
    logic                 w_valid;
    logic [PREG_BITS-1:0] w_pd;
    logic [ROB_BITS-1:0]  w_rob_idx;
    logic [XLEN-1:0]      w_data;
    logic                 w_mispred;
    logic [XLEN-1:0]      w_next_pc;

    // Resolve results (combinational from E)
    logic                 e_jump;
    logic                 e_taken;
    logic [XLEN-1:0]      e_base;
    logic [XLEN-1:0]      e_target;
    logic [XLEN-1:0]      e_pc4;
    logic [XLEN-1:0]      e_link;
    logic [PREG_BITS-1:0] e_pd_res;
    logic [XLEN-1:0]      e_next_pc;
    logic                 e_mispred;

    logic e_adv;
    logic accept;

    always_comb begin
        e_jump    = e_is_jal | e_is_jalr;
        e_taken   = 1'b0;
        case (e_funct3)
            F3_EQ:   e_taken = (e_rs1_v == e_rs2_v);
            F3_NE:   e_taken = (e_rs1_v != e_rs2_v);
            F3_LT:   e_taken = ($signed(e_rs1_v) <  $signed(e_rs2_v));
            F3_GE:   e_taken = ($signed(e_rs1_v) >= $signed(e_rs2_v));
            F3_LTU:  e_taken = (e_rs1_v <  e_rs2_v);
            F3_GEU:  e_taken = (e_rs1_v >= e_rs2_v);
            default: e_taken = 1'b0;
        endcase
        if (e_jump) begin
            e_taken = 1'b1;
        end

        // JALR adds to rs1 and clears bit 0; JAL and branches are PC-relative
        e_base   = e_is_jalr ? e_rs1_v : e_pc;
        e_target = e_base + e_imm;
        if (e_is_jalr) begin
            e_target[0] = 1'b0;
        end

        e_pc4     = e_pc + XLEN'(4);
        e_link    = e_jump ? e_pc4 : '0;
        e_pd_res  = e_jump ? e_pd : '0;
        e_next_pc = e_taken ? e_target : e_pc4;
        e_mispred = (e_taken != e_pred_taken) | (e_taken & (e_target != e_pred_target));
    end

    assign cdb_req     = w_valid;
    assign e_adv       = ~w_valid | (cdb_req & cdb_grant);
    assign br_is_ready = ~e_valid | e_adv;
    assign accept      = in_valid & br_is_ready & ~flush;

    assign cdb_valid        = cdb_req & cdb_grant & ~flush;
    assign cdb_pd           = w_pd;
    assign cdb_rob_idx      = w_rob_idx;
    assign cdb_data         = w_data;
    assign redirect_valid   = cdb_valid & w_mispred;
    assign redirect_pc      = w_next_pc;
    assign redirect_rob_idx = w_rob_idx;

    // E stage register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid       <= 1'b0;
            e_funct3      <= '0;
            e_is_jal      <= 1'b0;
            e_is_jalr     <= 1'b0;
            e_pc          <= '0;
            e_rs1_v       <= '0;
            e_rs2_v       <= '0;
            e_imm         <= '0;
            e_pd          <= '0;
            e_rob_idx     <= '0;
            e_pred_taken  <= 1'b0;
            e_pred_target <= '0;
        end else if (flush) begin
            e_valid <= 1'b0;
        end else if (accept) begin
            e_valid       <= 1'b1;
            e_funct3      <= in_funct3;
            e_is_jal      <= in_is_jal;
            e_is_jalr     <= in_is_jalr;
            e_pc          <= in_pc;
            e_rs1_v       <= in_rs1_v;
            e_rs2_v       <= in_rs2_v;
            e_imm         <= in_imm;
            e_pd          <= in_pd;
            e_rob_idx     <= in_rob_idx;
            e_pred_taken  <= in_pred_taken;
            e_pred_target <= in_pred_target;
        end else if (e_valid && e_adv) begin
            e_valid <= 1'b0;
        end
    end

    // W stage register: reloads from E on advance, otherwise clears on grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_valid   <= 1'b0;
            w_pd      <= '0;
            w_rob_idx <= '0;
            w_data    <= '0;
            w_mispred <= 1'b0;
            w_next_pc <= '0;
        end else if (flush) begin
            w_valid <= 1'b0;
        end else if (e_valid && e_adv) begin
            w_valid   <= 1'b1;
            w_pd      <= e_pd_res;
            w_rob_idx <= e_rob_idx;
            w_data    <= e_link;
            w_mispred <= e_mispred;
            w_next_pc <= e_next_pc;
        end else if (cdb_req && cdb_grant) begin
            w_valid <= 1'b0;
        end
    end

    // Saturating mispredict counter; survives flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispred_cnt <= '0;
        end else if (redirect_valid && (mispred_cnt != 32'hFFFF_FFFF)) begin
            mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_br_exec_unit.sv
// Directed bench for br_exec_unit with hand-computed expectations.
module tb_br_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        br_is_ready;
    logic [2:0]  in_funct3;
    logic        in_is_jal;
    logic        in_is_jalr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_v;
    logic [31:0] in_rs2_v;
    logic [31:0] in_imm;
    logic [5:0]  in_pd;
    logic [4:0]  in_rob_idx;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;
    logic        cdb_req;
    logic        cdb_grant;
    logic        cdb_valid;
    logic [5:0]  cdb_pd;
    logic [4:0]  cdb_rob_idx;
    logic [31:0] cdb_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [4:0]  redirect_rob_idx;
    logic [31:0] mispred_cnt;

    int vectors = 0;
    int errors  = 0;

    br_exec_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .br_is_ready(br_is_ready),
        .in_funct3(in_funct3), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr), .in_pc(in_pc),
        .in_rs1_v(in_rs1_v), .in_rs2_v(in_rs2_v), .in_imm(in_imm), .in_pd(in_pd),
        .in_rob_idx(in_rob_idx), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
        .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_rob_idx(redirect_rob_idx), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic jal, input logic jalr,
                         input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input logic [5:0] pd, input logic [4:0] rob,
                         input logic pt, input logic [31:0] ptgt);
        in_valid       = 1'b1;
        in_funct3      = f3;
        in_is_jal      = jal;
        in_is_jalr     = jalr;
        in_pc          = pc;
        in_rs1_v       = r1;
        in_rs2_v       = r2;
        in_imm         = imm;
        in_pd          = pd;
        in_rob_idx     = rob;
        in_pred_taken  = pt;
        in_pred_target = ptgt;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; cdb_grant = 1'b0;
        issue(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 6'd0, 5'd0, 1'b0, 32'h0);
        in_valid = 1'b0;
        #12;
        chk("rst_ready", 32'(br_is_ready), 32'd1);
        chk("rst_cdb_req", 32'(cdb_req), 32'd0);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_cnt", mispred_cnt, 32'd0);
        rst = 1'b1;
        step();

        // BEQ taken, correctly predicted
        issue(3'b000, 1'b0, 1'b0, 32'h100, 32'd5, 32'd5, 32'h20, 6'd9, 5'd1, 1'b1, 32'h120);
        cdb_grant = 1'b1;
        #2;
        chk("beq_ready", 32'(br_is_ready), 32'd1);
        chk("beq_req_n", 32'(cdb_req), 32'd0);
        step(); in_valid = 1'b0; #2;
        chk("beq_req_n1", 32'(cdb_req), 32'd0);
        step(); #2;
        chk("beq_cdb_valid", 32'(cdb_valid), 32'd1);
        chk("beq_pd", 32'(cdb_pd), 32'd0);
        chk("beq_data", cdb_data, 32'd0);
        chk("beq_rob", 32'(cdb_rob_idx), 32'd1);
        chk("beq_redirect", 32'(redirect_valid), 32'd0);
        step(); #2;
        chk("beq_drained", 32'(cdb_req), 32'd0);

        // BLT signed taken, predicted not-taken
        issue(3'b100, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 6'd4, 5'd2, 1'b0, 32'h0);
        step(); in_valid = 1'b0;
        step(); #2;
        chk("blt_redirect", 32'(redirect_valid), 32'd1);
        chk("blt_redirect_pc", redirect_pc, 32'h240);
        chk("blt_redirect_rob", 32'(redirect_rob_idx), 32'd2);
        step(); #2;
        chk("blt_cnt", mispred_cnt, 32'd1);

        // JALR wrong target
        issue(3'b000, 1'b0, 1'b1, 32'h300, 32'h1003, 32'h0, 32'h4, 6'd7, 5'd3, 1'b1, 32'h1007);
        step(); in_valid = 1'b0;
        step(); #2;
        chk("jalr_data", cdb_data, 32'h304);
        chk("jalr_pd", 32'(cdb_pd), 32'd7);
        chk("jalr_redirect", 32'(redirect_valid), 32'd1);
        chk("jalr_redirect_pc", redirect_pc, 32'h1006);
        step(); #2;
        chk("jalr_cnt", mispred_cnt, 32'd2);

        // funct3=010 resolves not-taken: predicted taken -> redirect to pc+4
        issue(3'b010, 1'b0, 1'b0, 32'h700, 32'h0, 32'h0, 32'h10, 6'd1, 5'd5, 1'b1, 32'h710);
        step(); in_valid = 1'b0;
        step(); #2;
        chk("f010_redirect", 32'(redirect_valid), 32'd1);
        chk("f010_redirect_pc", redirect_pc, 32'h704);

        // BGEU 0xFFFFFFFF >= 1 taken, correctly predicted
        issue(3'b111, 1'b0, 1'b0, 32'h800, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 6'd1, 5'd6, 1'b1, 32'h7F8);
        step(); in_valid = 1'b0;
        step(); #2;
        chk("bgeu_valid", 32'(cdb_valid), 32'd1);
        chk("bgeu_redirect", 32'(redirect_valid), 32'd0);
        chk("bgeu_next_pc", redirect_pc, 32'h7F8);
        step(); #2;
        chk("bgeu_cnt", mispred_cnt, 32'd3);

        // Back-to-back issue under a stalled CDB
        cdb_grant = 1'b0;
        issue(3'b000, 1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 32'h10, 6'd1, 5'd10, 1'b1, 32'h410);
        #2; chk("b2b_ready1", 32'(br_is_ready), 32'd1);
        step();
        issue(3'b000, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 32'h10, 6'd2, 5'd11, 1'b1, 32'h510);
        #2; chk("b2b_ready2", 32'(br_is_ready), 32'd1);
        step();
        issue(3'b000, 1'b1, 1'b0, 32'h600, 32'h0, 32'h0, 32'h10, 6'd3, 5'd12, 1'b1, 32'h610);
        #2;
        chk("b2b_ready_low", 32'(br_is_ready), 32'd0);
        chk("b2b_req", 32'(cdb_req), 32'd1);
        chk("b2b_valid_n", 32'(cdb_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); #2;
            chk("b2b_stall_ready", 32'(br_is_ready), 32'd0);
            chk("b2b_stall_pd", 32'(cdb_pd), 32'd1);
            chk("b2b_stall_data", cdb_data, 32'h404);
        end
        step(); cdb_grant = 1'b1; #2;
        chk("b2b_i1_valid", 32'(cdb_valid), 32'd1);
        chk("b2b_i1_data", cdb_data, 32'h404);
        chk("b2b_i3_ready", 32'(br_is_ready), 32'd1);
        step(); in_valid = 1'b0; #2;
        chk("b2b_i2_valid", 32'(cdb_valid), 32'd1);
        chk("b2b_i2_pd", 32'(cdb_pd), 32'd2);
        chk("b2b_i2_data", cdb_data, 32'h504);
        step(); #2;
        chk("b2b_i3_valid", 32'(cdb_valid), 32'd1);
        chk("b2b_i3_pd", 32'(cdb_pd), 32'd3);
        chk("b2b_i3_data", cdb_data, 32'h604);
        step(); #2;
        chk("b2b_empty", 32'(cdb_req), 32'd0);

        // Flush with E and W full and the grant asserted
        cdb_grant = 1'b0;
        issue(3'b100, 1'b0, 1'b0, 32'h900, 32'hFFFF_FFFF, 32'd1, 32'h40, 6'd4, 5'd4, 1'b0, 32'h0);
        step();
        issue(3'b000, 1'b1, 1'b0, 32'hA00, 32'h0, 32'h0, 32'h8, 6'd5, 5'd7, 1'b0, 32'h0);
        step();
        issue(3'b000, 1'b1, 1'b0, 32'hB00, 32'h0, 32'h0, 32'h8, 6'd6, 5'd8, 1'b0, 32'h0);
        flush = 1'b1; cdb_grant = 1'b1; #2;
        chk("flush_req", 32'(cdb_req), 32'd1);
        chk("flush_valid", 32'(cdb_valid), 32'd0);
        chk("flush_redirect", 32'(redirect_valid), 32'd0);
        step(); flush = 1'b0; in_valid = 1'b0; #2;
        chk("flush_ready", 32'(br_is_ready), 32'd1);
        chk("flush_req_after", 32'(cdb_req), 32'd0);
        chk("flush_cnt", mispred_cnt, 32'd3);
        step(); #2;
        chk("flush_dropped", 32'(cdb_req), 32'd0);

        // Asynchronous reset in the middle of a stall
        cdb_grant = 1'b0;
        issue(3'b000, 1'b1, 1'b0, 32'hC00, 32'h0, 32'h0, 32'h8, 6'd6, 5'd9, 1'b0, 32'h0);
        step();
        issue(3'b000, 1'b1, 1'b0, 32'hD00, 32'h0, 32'h0, 32'h8, 6'd7, 5'd13, 1'b0, 32'h0);
        step(); in_valid = 1'b0; #2;
        chk("stall_req", 32'(cdb_req), 32'd1);
        #1; rst = 1'b0; cdb_grant = 1'b1; #1;
        chk("arst_req", 32'(cdb_req), 32'd0);
        chk("arst_valid", 32'(cdb_valid), 32'd0);
        chk("arst_redirect", 32'(redirect_valid), 32'd0);
        chk("arst_ready", 32'(br_is_ready), 32'd1);
        chk("arst_pd", 32'(cdb_pd), 32'd0);
        chk("arst_redirect_pc", redirect_pc, 32'd0);
        chk("arst_cnt", mispred_cnt, 32'd0);
        #2; rst = 1'b1;
        step(); #2;
        chk("arst_post_req", 32'(cdb_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
